pipelined_chunk_adder: RTL and testbench

//  Parametrised, pipelined successor to the fixed 16-bit chained 4-bit adder: WIDTH-bit add/subtract built from CHUNK-bit slices.
//  One slice is evaluated per pipeline stage, with the carry registered between stages, so throughput is one operation per cycle.

---
 rtl/pipelined_chunk_adder_pkg.sv | 16 +
 rtl/pipelined_chunk_adder_slice.sv | 28 ++
 rtl/pipelined_chunk_adder.sv | 125 ++++++++++++
 tb/tb_pipelined_chunk_adder.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_chunk_adder_pkg.sv
// Shared types for the pipelined chunk adder.
// Operation mode, per-stage valid type and stage-count helper.
package pipelined_chunk_adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef logic stage_valid_t;

    function automatic int stages(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/pipelined_chunk_adder_slice.sv
// CHUNK-bit combinational ripple slice for the pipelined chunk adder.
// Also exposes the carry into its MSB for signed-overflow detection.
module chunk_adder_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic c;

    always_comb begin
        c        = cin;
        sum      = '0;
        c_msb_in = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) c_msb_in = c;
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/pipelined_chunk_adder.sv
// Pipelined WIDTH-bit add/sub, one CHUNK-bit slice per stage, valid/ready both sides.
// Optional output clamp on signed overflow: PIPELINED_CHUNK_ADDER_SAT_EN.
module pipelined_chunk_adder
    import pipelined_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_c,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_c,
    output logic             out_ovf
);

    localparam int STAGES = stages(WIDTH, CHUNK);
    localparam int MSB    = WIDTH - 1;

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("WIDTH must be a non-zero multiple of CHUNK");
    end

    op_e              op;
    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin;

    assign op       = op_e'(in_sub);
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_eff    = (op == OP_SUB) ? ~in_b : in_b;
    assign cin      = (op == OP_SUB) ? ~in_c : in_c;

    stage_valid_t     v_q   [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic [WIDTH-1:0] s_nxt [STAGES];
    logic             c_q   [STAGES];

    logic [CHUNK-1:0] slice_sum  [STAGES];
    logic             slice_cout [STAGES];
    logic             slice_cmsb [STAGES];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        localparam int LO = i * CHUNK;
        localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}}) << LO;

        chunk_adder_slice #(
            .CHUNK(CHUNK)
        ) u_slice (
            .a        (a_q[i][LO +: CHUNK]),
            .b        (b_q[i][LO +: CHUNK]),
            .cin      (c_q[i]),
            .sum      (slice_sum[i]),
            .cout     (slice_cout[i]),
            .c_msb_in (slice_cmsb[i])
        );

        // Merge this stage's slice into the result collected so far.
        assign s_nxt[i] = (s_q[i] & ~MASK) | (WIDTH'(slice_sum[i]) << LO);
    end

    logic [WIDTH-1:0] res_sum;
    logic             res_c;
    logic             res_ovf;

    assign res_c   = slice_cout[STAGES-1];
    assign res_ovf = slice_cmsb[STAGES-1] ^ res_c;

`ifdef PIPELINED_CHUNK_ADDER_SAT_EN
    localparam logic [WIDTH-1:0] SMIN = WIDTH'(1) << MSB;
    localparam logic [WIDTH-1:0] SMAX = ~SMIN;

    // A wrapped negative result means the true value overflowed upward.
    always_comb begin
        res_sum = s_nxt[STAGES-1];
        if (res_ovf) res_sum = s_nxt[STAGES-1][MSB] ? SMAX : SMIN;
    end
`else
    assign res_sum = s_nxt[STAGES-1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                v_q[i] <= 1'b0;
                a_q[i] <= '0;
                b_q[i] <= '0;
                s_q[i] <= '0;
                c_q[i] <= 1'b0;
            end
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_c     <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (adv) begin
            v_q[0] <= in_valid;
            a_q[0] <= in_a;
            b_q[0] <= b_eff;
            s_q[0] <= '0;
            c_q[0] <= cin;
            for (int i = 1; i < STAGES; i++) begin
                v_q[i] <= v_q[i-1];
                a_q[i] <= a_q[i-1];
                b_q[i] <= b_q[i-1];
                s_q[i] <= s_nxt[i-1];
                c_q[i] <= slice_cout[i-1];
            end
            out_valid <= v_q[STAGES-1];
            out_sum   <= res_sum;
            out_c     <= res_c;
            out_ovf   <= res_ovf;
        end
    end

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// Bench for pipelined_chunk_adder: 16/4, 32/8 and 8/8 instances.
// Table vectors plus random ops checked through a shared scoreboard queue.
module tb_pipelined_chunk_adder;

    typedef struct {
        int          dut;
        logic [31:0] sum;
        logic        c;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic        sub;
        logic [15:0] sum;
        logic        c_o;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld   [3];
    logic        rdy   [3];
    logic        c_s   [3];
    logic        sub_s [3];
    logic [31:0] a_s   [3];
    logic [31:0] b_s   [3];
    logic        ir_s  [3];
    logic        ov_s  [3];
    logic        oc_s  [3];
    logic        oo_s  [3];
    logic [31:0] sum_s [3];

    int   errors = 0;
    int   checks = 0;
    int   pops   = 0;
    exp_t sb[$];

    logic        held [3];
    logic [31:0] hs   [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 16 : (g == 1) ? 32 : 8;
        localparam int C = (g == 0) ? 4 : 8;
        logic [W-1:0] sum_l;
        logic         ir_l, ov_l, oc_l, oo_l;

        pipelined_chunk_adder #(
            .WIDTH(W),
            .CHUNK(C)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (vld[g]),
            .in_ready  (ir_l),
            .in_a      (a_s[g][W-1:0]),
            .in_b      (b_s[g][W-1:0]),
            .in_c      (c_s[g]),
            .in_sub    (sub_s[g]),
            .out_valid (ov_l),
            .out_ready (rdy[g]),
            .out_sum   (sum_l),
            .out_c     (oc_l),
            .out_ovf   (oo_l)
        );

        assign sum_s[g] = 32'(sum_l);
        assign ir_s[g]  = ir_l;
        assign ov_s[g]  = ov_l;
        assign oc_s[g]  = oc_l;
        assign oo_s[g]  = oo_l;

        always @(negedge clk) mon(g);
    end

    function automatic int wof(input int d);
        return (d == 0) ? 16 : (d == 1) ? 32 : 8;
    endfunction

    function automatic exp_t model(input int d, input logic [31:0] a,
                                   input logic [31:0] b, input logic c,
                                   input logic sub);
        exp_t        e;
        int          w;
        logic [32:0] m, lm, bb, full, low;
        logic        ci;
        w    = wof(d);
        m    = (33'd1 << w) - 33'd1;
        lm   = m >> 1;
        bb   = (sub ? {1'b0, ~b} : {1'b0, b}) & m;
        ci   = sub ? ~c : c;
        full = ({1'b0, a} & m) + bb + 33'(ci);
        low  = ({1'b0, a} & lm) + (bb & lm) + 33'(ci);
        e.dut = d;
        e.sum = full[31:0] & m[31:0];
        e.c   = full[w];
        e.ovf = low[w-1] ^ full[w];
`ifdef PIPELINED_CHUNK_ADDER_SAT_EN
        if (e.ovf)
            e.sum = e.sum[w-1] ? lm[31:0] : (32'd1 << (w - 1));
`endif
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic mon(input int d);
        exp_t e;
        if (rst) begin
            held[d] = 1'b0;
            return;
        end
        chk("in_ready", 32'(ir_s[d]), 32'(!ov_s[d] || rdy[d]));
        if (held[d]) begin
            chk("hold_valid", 32'(ov_s[d]), 32'd1);
            chk("hold_sum", sum_s[d], hs[d]);
        end
        held[d] = ov_s[d] && !rdy[d];
        hs[d]   = sum_s[d];
        if (ov_s[d] && rdy[d]) begin
            if (sb.size() == 0 || sb[0].dut != d) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: dut %0d sum %h", d, sum_s[d]);
            end else begin
                e = sb.pop_front();
                pops++;
                chk("out_sum", sum_s[d], e.sum);
                chk("out_c", 32'(oc_s[d]), 32'(e.c));
                chk("out_ovf", 32'(oo_s[d]), 32'(e.ovf));
            end
        end
    endtask

    task automatic send(input int d, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic sub, input exp_t e);
        int   n;
        logic acc;
        a_s[d]   = a;
        b_s[d]   = b;
        c_s[d]   = c;
        sub_s[d] = sub;
        vld[d]   = 1'b1;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = ir_s[d] && !rst;
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: dut %0d in_ready %b want 1", d, ir_s[d]);
        end else begin
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        vld[d] = 1'b0;
    endtask

    task automatic send_rand(input int d);
        logic [31:0] a, b;
        logic        c, sub;
        a   = $urandom;
        b   = $urandom;
        c   = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        send(d, a, b, c, sub, model(d, a, b, c, sub));
    endtask

    task automatic lat(input int d, input int want);
        int n = 0;
        while (!ov_s[d] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 32'(n), 32'(want));
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic send_vec(input vec_t v);
        exp_t e;
        e.dut = 0;
        e.sum = 32'(v.sum);
        e.c   = v.c_o;
        e.ovf = v.ovf;
        send(0, 32'(v.a), 32'(v.b), v.c, v.sub, e);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        logic pat[4];
        int   p0;

        tbl[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[5] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};
        tbl[6] = '{16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0};
        tbl[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
`ifdef PIPELINED_CHUNK_ADDER_SAT_EN
        tbl[2].sum = 16'h7FFF;
        tbl[4].sum = 16'h8000;
        tbl[7].sum = 16'h8000;
`endif
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        for (int d = 0; d < 3; d++) begin
            vld[d]   = 1'b0;
            rdy[d]   = 1'b1;
            a_s[d]   = '0;
            b_s[d]   = '0;
            c_s[d]   = 1'b0;
            sub_s[d] = 1'b0;
            held[d]  = 1'b0;
            hs[d]    = '0;
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(ov_s[0]), 32'd0);
        chk("rst_out_sum", sum_s[0], 32'd0);
        chk("rst_out_c", 32'(oc_s[0]), 32'd0);
        chk("rst_out_ovf", 32'(oo_s[0]), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(ir_s[0]), 32'd1);
        @(posedge clk);
        #1;

        send_vec(tbl[0]);
        lat(0, 4);
        drain();

        for (int i = 1; i < 8; i++) send_vec(tbl[i]);
        drain();

        p0 = pops;
        fork
            begin
                for (int i = 0; i < 8; i++) send_rand(0);
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    rdy[0] = pat[k % 4];
                    @(posedge clk);
                    #1;
                end
                rdy[0] = 1'b1;
            end
        join
        drain();
        chk("stream_count", 32'(pops - p0), 32'd8);

        for (int i = 0; i < 3; i++) send_rand(0);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_out_valid", 32'(ov_s[0]), 32'd0);
        repeat (6) begin
            @(posedge clk);
            #1;
            chk("no_stale", 32'(ov_s[0]), 32'd0);
        end
        send_rand(0);
        lat(0, 4);
        drain();

        send_rand(1);
        lat(1, 4);
        for (int i = 0; i < 6; i++) send_rand(1);
        drain();

        send_rand(2);
        lat(2, 1);
        for (int i = 0; i < 6; i++) send_rand(2);
        drain();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
